spec_rat_ckpt: RTL

Parametrised speculative register alias table for the rename stage, with an internal architectural RAT, branch checkpoints and flush recovery. Renames up to RENAME_W instructions per cycle with intra-group bypass in program order. Snapshots the speculative map per branch and restores it in one cycle on mispredict. Rebuilds the map from the committed (architectural) table on a full pipeline flush.

---
 rtl/spec_rat_ckpt.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/spec_rat_ckpt.sv
// Speculative register alias table with architectural copy, branch checkpoints and
// single-cycle mispredict/flush recovery for the rename stage.
module spec_rat_ckpt #(
    parameter int unsigned NUM_LREG = 32,
    parameter int unsigned PREG_W   = 6,
    parameter int unsigned RENAME_W = 2,
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned NUM_CKPT = 4,
    localparam int unsigned LW = $clog2(NUM_LREG),
    localparam int unsigned CW = $clog2(NUM_CKPT),
    localparam int unsigned SW = (RENAME_W > 2) ? $clog2(RENAME_W) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [RENAME_W*LW-1:0]       i_rd_lrs1,
    input  logic [RENAME_W*LW-1:0]       i_rd_lrs2,
    input  logic [RENAME_W*LW-1:0]       i_rd_lrd,
    input  logic [RENAME_W-1:0]          i_rd_lrs1_vld,
    input  logic [RENAME_W-1:0]          i_rd_lrs2_vld,
    input  logic [RENAME_W-1:0]          i_rd_lrd_vld,
    output logic [RENAME_W*PREG_W-1:0]   o_rd_prs1,
    output logic [RENAME_W*PREG_W-1:0]   o_rd_prs2,
    output logic [RENAME_W*PREG_W-1:0]   o_rd_prd_old,
    input  logic [RENAME_W-1:0]          i_wr_en,
    input  logic [RENAME_W*LW-1:0]       i_wr_lrd,
    input  logic [RENAME_W*PREG_W-1:0]   i_wr_prd,
    input  logic [COMMIT_W-1:0]          i_cmt_en,
    input  logic [COMMIT_W*LW-1:0]       i_cmt_lrd,
    input  logic [COMMIT_W*PREG_W-1:0]   i_cmt_prd,
    input  logic                         i_ckpt_alloc,
    input  logic [SW-1:0]                i_ckpt_slot,
    output logic [CW-1:0]                o_ckpt_id,
    output logic                         o_ckpt_full,
    input  logic                         i_ckpt_release,
    input  logic                         i_restore,
    input  logic [CW-1:0]                i_restore_id,
    input  logic                         i_flush
);

    typedef logic [PREG_W-1:0] preg_t;

    preg_t r_spec [NUM_LREG];
    preg_t r_arch [NUM_LREG];
    preg_t r_ckpt [NUM_CKPT][NUM_LREG];

    logic [CW-1:0] r_head;
    logic [CW-1:0] r_tail;
    logic [CW:0]   r_count;

    preg_t w_spec_nxt [NUM_LREG];
    preg_t w_ckpt_img [NUM_LREG];
    preg_t w_arch_nxt [NUM_LREG];

    logic          w_full;
    logic          w_alloc;
    logic          w_rel;
    logic [CW-1:0] w_head_inc;
    logic [CW-1:0] w_rst_diff;
    logic [CW:0]   w_rst_count;

    // Mapping seen by slot j: youngest older in-group writer wins, else the table.
    function automatic preg_t lookup(input int unsigned j, input logic [LW-1:0] l);
        preg_t v;
        v = r_spec[l];
        for (int unsigned k = 0; k < j; k++) begin
            if (i_wr_en[k] && (i_wr_lrd[k*LW +: LW] == l)) begin
                v = i_wr_prd[k*PREG_W +: PREG_W];
            end
        end
        if (l == '0) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        o_rd_prs1    = '0;
        o_rd_prs2    = '0;
        o_rd_prd_old = '0;
        for (int unsigned j = 0; j < RENAME_W; j++) begin
            if (i_rd_lrs1_vld[j]) o_rd_prs1[j*PREG_W +: PREG_W] = lookup(j, i_rd_lrs1[j*LW +: LW]);
            if (i_rd_lrs2_vld[j]) o_rd_prs2[j*PREG_W +: PREG_W] = lookup(j, i_rd_lrs2[j*LW +: LW]);
            if (i_rd_lrd_vld[j]) o_rd_prd_old[j*PREG_W +: PREG_W] = lookup(j, i_rd_lrd[j*LW +: LW]);
        end
    end

    // Checkpoint image is the map after the branch's own slot, excluding younger slots.
    always_comb begin
        w_spec_nxt = r_spec;
        w_ckpt_img = r_spec;
        for (int unsigned s = 0; s < RENAME_W; s++) begin
            if (i_wr_en[s] && (i_wr_lrd[s*LW +: LW] != '0)) begin
                w_spec_nxt[i_wr_lrd[s*LW +: LW]] = i_wr_prd[s*PREG_W +: PREG_W];
            end
            if (SW'(s) <= i_ckpt_slot) begin
                w_ckpt_img = w_spec_nxt;
            end
        end
    end

    always_comb begin
        w_arch_nxt = r_arch;
        for (int unsigned s = 0; s < COMMIT_W; s++) begin
            if (i_cmt_en[s] && (i_cmt_lrd[s*LW +: LW] != '0)) begin
                w_arch_nxt[i_cmt_lrd[s*LW +: LW]] = i_cmt_prd[s*PREG_W +: PREG_W];
            end
        end
    end

    assign w_full      = (r_count == (CW+1)'(NUM_CKPT));
    assign w_alloc     = i_ckpt_alloc && !w_full;
    assign w_rel       = i_ckpt_release && (r_count != '0);
    assign w_head_inc  = w_rel ? (r_head + CW'(1)) : r_head;
    assign w_rst_diff  = i_restore_id + CW'(1) - w_head_inc;
    // A zero distance means every entry up to the restored one is still live.
    assign w_rst_count = (w_rst_diff == '0) ? (CW+1)'(NUM_CKPT) : {1'b0, w_rst_diff};

    assign o_ckpt_id   = r_tail;
    assign o_ckpt_full = w_full;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < NUM_LREG; i++) begin
                r_spec[i] <= PREG_W'(i);
                r_arch[i] <= PREG_W'(i);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_arch <= w_arch_nxt;
            if (i_flush) begin
                r_spec  <= w_arch_nxt;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else if (i_restore) begin
                r_spec  <= r_ckpt[i_restore_id];
                r_head  <= w_head_inc;
                r_tail  <= i_restore_id + CW'(1);
                r_count <= w_rst_count;
            end else begin
                r_spec  <= w_spec_nxt;
                r_head  <= w_head_inc;
                if (w_alloc) begin
                    r_tail <= r_tail + CW'(1);
                end
                r_count <= r_count + (CW+1)'(w_alloc) - (CW+1)'(w_rel);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_alloc && !i_flush && !i_restore) begin
            r_ckpt[r_tail] <= w_ckpt_img;
        end
    end

endmodule
